axis_quad_join_ctrl: RTL and testbench

Flow controller placed in front of the four-input AXI-Stream quad adder. It joins four independent 128-bit sample streams into one lock-step 512-bit beat, so all four lanes are consumed in the same cycle. It frames the joined stream with a programmable beat count and generates the output tlast. It checks each input tlast against that frame boundary, and on a mismatch it halts in an error state until software clears it.

---
 rtl/axis_quad_join_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_axis_quad_join_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_quad_join_ctrl.sv
// ---------------------------------------------------------------------------
// axis_quad_join_ctrl
//
// Joins four independent AXI-Stream sample lanes into one lock-step beat for
// the quad adder. All four lanes are consumed in the same cycle or not at
// all. The joined stream is framed with a programmable beat count, and the
// module generates the output tlast itself. Every input tlast is checked
// against that frame boundary. On a mismatch the block parks in ERROR until
// clear_err is pulsed.
//
// Ports
//   CLK, resetn            clock, synchronous active-low reset
//   enable                 run request (sampled in IDLE and at frame end)
//   frame_len              beats per frame, latched at frame start
//   clear_err              pulse that leaves ERROR
//   sN_axis_* (N=0..3)     input lanes; tready is common to all lanes
//   m_axis_*               joined 4*SDATA_WIDTH output stream, lane 0 in LSBs
//   busy                   state != IDLE
//   frame_done             pulse the cycle after a tlast beat handshakes
//   err_tlast              sticky tlast-mismatch flag
//   beat_count             beats joined so far in the current frame
// ---------------------------------------------------------------------------
module axis_quad_join_ctrl #(
    parameter int unsigned SDATA_WIDTH = 128,
    parameter int unsigned LEN_WIDTH   = 16
) (
    input  logic                     CLK,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic [LEN_WIDTH-1:0]     frame_len,
    input  logic                     clear_err,
    input  logic [SDATA_WIDTH-1:0]   s0_axis_tdata,
    input  logic                     s0_axis_tvalid,
    input  logic                     s0_axis_tlast,
    output logic                     s0_axis_tready,
    input  logic [SDATA_WIDTH-1:0]   s1_axis_tdata,
    input  logic                     s1_axis_tvalid,
    input  logic                     s1_axis_tlast,
    output logic                     s1_axis_tready,
    input  logic [SDATA_WIDTH-1:0]   s2_axis_tdata,
    input  logic                     s2_axis_tvalid,
    input  logic                     s2_axis_tlast,
    output logic                     s2_axis_tready,
    input  logic [SDATA_WIDTH-1:0]   s3_axis_tdata,
    input  logic                     s3_axis_tvalid,
    input  logic                     s3_axis_tlast,
    output logic                     s3_axis_tready,
    output logic [4*SDATA_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     err_tlast,
    output logic [LEN_WIDTH-1:0]     beat_count
);

    localparam int unsigned MDATA_WIDTH = 4 * SDATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } state_e;

    state_e                 state_q,      state_d;
    logic [LEN_WIDTH-1:0]   frame_len_q,  frame_len_d;
    logic [LEN_WIDTH-1:0]   beat_count_q, beat_count_d;
    logic [MDATA_WIDTH-1:0] tdata_q,      tdata_d;
    logic                   tvalid_q,     tvalid_d;
    logic                   tlast_q,      tlast_d;
    logic                   err_q,        err_d;
    logic                   done_q,       done_d;

    logic       can_accept_c;
    logic       all_valid_c;
    logic       fire_c;
    logic       gen_last_c;
    logic       mismatch_c;
    logic [3:0] lane_last_c;

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q      <= IDLE;
            frame_len_q  <= '0;
            beat_count_q <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_len_q  <= frame_len_d;
            beat_count_q <= beat_count_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    // Join, framing and error handling
    always_comb begin
        state_d      = state_q;
        frame_len_d  = frame_len_q;
        beat_count_d = beat_count_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        err_d        = err_q;
        done_d       = tvalid_q && m_axis_tready && tlast_q;
        fire_c       = 1'b0;

        can_accept_c = !tvalid_q || m_axis_tready;
        all_valid_c  = s0_axis_tvalid && s1_axis_tvalid && s2_axis_tvalid && s3_axis_tvalid;
        // frame_len_q is never 0 while in RUN, so the subtraction cannot wrap there
        gen_last_c   = (beat_count_q == (frame_len_q - LEN_WIDTH'(1)));
        lane_last_c  = {s3_axis_tlast, s2_axis_tlast, s1_axis_tlast, s0_axis_tlast};
        mismatch_c   = (lane_last_c != {4{gen_last_c}});

        if (state_q == RUN) begin
            fire_c = all_valid_c && can_accept_c;
        end

        // Output register: load on fire, drain when the consumer takes the beat
        if (fire_c) begin
            tdata_d      = {s3_axis_tdata, s2_axis_tdata, s1_axis_tdata, s0_axis_tdata};
            tvalid_d     = 1'b1;
            // a mismatched beat is forwarded as a frame end so the adder closes it
            tlast_d      = gen_last_c || mismatch_c;
            beat_count_d = gen_last_c ? '0 : beat_count_q + LEN_WIDTH'(1);
        end else if (can_accept_c) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (enable && (frame_len != '0)) begin
                    frame_len_d  = frame_len;
                    beat_count_d = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (fire_c) begin
                    if (mismatch_c) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end else if (gen_last_c) begin
                        // back-to-back frames without a bubble while enable holds
                        if (enable && (frame_len != '0)) begin
                            frame_len_d = frame_len;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            ERROR: begin
                if (clear_err) begin
                    err_d        = 1'b0;
                    beat_count_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One shared ready: a lane is never consumed on its own
    assign s0_axis_tready = fire_c;
    assign s1_axis_tready = fire_c;
    assign s2_axis_tready = fire_c;
    assign s3_axis_tready = fire_c;

    assign m_axis_tdata   = tdata_q;
    assign m_axis_tvalid  = tvalid_q;
    assign m_axis_tlast   = tlast_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = done_q;
    assign err_tlast      = err_q;
    assign beat_count     = beat_count_q;

endmodule

// File: tb/tb_axis_quad_join_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axis_quad_join_ctrl
//
// Scoreboard bench for axis_quad_join_ctrl. Each joined beat that the
// stimulus issues pushes its expected {tlast, tdata} into a queue. An
// independent monitor pops and compares on every output handshake. The
// monitor also checks output stability and input back-pressure while the
// output is stalled.
// ---------------------------------------------------------------------------
module tb_axis_quad_join_ctrl;

    localparam int unsigned SW = 128;
    localparam int unsigned LW = 16;

    logic            CLK;
    logic            resetn;
    logic            enable;
    logic [LW-1:0]   frame_len;
    logic            clear_err;
    logic [SW-1:0]   sd0, sd1, sd2, sd3;
    logic [3:0]      sv;
    logic [3:0]      sl;
    logic            tr0, tr1, tr2, tr3;
    logic [4*SW-1:0] m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_rdy;
    logic            busy;
    logic            frame_done;
    logic            err_tlast;
    logic [LW-1:0]   beat_count;

    axis_quad_join_ctrl #(.SDATA_WIDTH(SW), .LEN_WIDTH(LW)) dut (
        .CLK            (CLK),
        .resetn         (resetn),
        .enable         (enable),
        .frame_len      (frame_len),
        .clear_err      (clear_err),
        .s0_axis_tdata  (sd0),
        .s0_axis_tvalid (sv[0]),
        .s0_axis_tlast  (sl[0]),
        .s0_axis_tready (tr0),
        .s1_axis_tdata  (sd1),
        .s1_axis_tvalid (sv[1]),
        .s1_axis_tlast  (sl[1]),
        .s1_axis_tready (tr1),
        .s2_axis_tdata  (sd2),
        .s2_axis_tvalid (sv[2]),
        .s2_axis_tlast  (sl[2]),
        .s2_axis_tready (tr2),
        .s3_axis_tdata  (sd3),
        .s3_axis_tvalid (sv[3]),
        .s3_axis_tlast  (sl[3]),
        .s3_axis_tready (tr3),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_rdy),
        .busy           (busy),
        .frame_done     (frame_done),
        .err_tlast      (err_tlast),
        .beat_count     (beat_count)
    );

    int           pass_cnt  = 0;
    int           total_cnt = 0;
    int           fd_cnt    = 0;
    int           cyc       = 0;
    logic [4*SW:0] sb[$];
    logic         hold_v    = 1'b0;
    logic [4*SW:0] hold_beat;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk_int(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_beat(input string name, input logic [4*SW:0] act, input logic [4*SW:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Lane word: lane id and beat index repeated across all 16 bytes
    function automatic logic [SW-1:0] lw(input int lane, input int b);
        return {8{8'(lane), 8'(b)}};
    endfunction

    function automatic logic [4*SW-1:0] joined(input int b);
        return {lw(3, b), lw(2, b), lw(1, b), lw(0, b)};
    endfunction

    function automatic int treadys();
        return int'({tr3, tr2, tr1, tr0});
    endfunction

    // Output monitor: scoreboard pop on handshake, stability check on stall
    always @(negedge CLK) begin
        if (!resetn) begin
            hold_v = 1'b0;
        end else begin
            if (frame_done) fd_cnt++;
            if (hold_v && m_tvalid) chk_beat("stall_hold", {m_tlast, m_tdata}, hold_beat);
            hold_v = 1'b0;
            if (m_tvalid && m_rdy) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_beat: got %0h expected none", {m_tlast, m_tdata});
                end else begin
                    chk_beat("beat", {m_tlast, m_tdata}, sb.pop_front());
                end
            end else if (m_tvalid) begin
                hold_v    = 1'b1;
                hold_beat = {m_tlast, m_tdata};
                chk_int("stall_tready", treadys(), 0);
            end
        end
    end

    // Present one beat on all lanes and wait (bounded) until it is joined
    task automatic send(input int b, input logic [3:0] lasts, input logic exp_last);
        int n;
        sd0 = lw(0, b); sd1 = lw(1, b); sd2 = lw(2, b); sd3 = lw(3, b);
        sl  = lasts;
        sv  = 4'hF;
        sb.push_back({exp_last, joined(b)});
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!tr0 && n < 100);
        chk_int("fire_tready", treadys(), 15);
        @(posedge CLK);
        #1;
        sv = 4'h0;
        sl = 4'h0;
    endtask

    task automatic check_idle_zero(input string tag);
        chk_int({tag, "_tvalid"}, int'(m_tvalid), 0);
        chk_int({tag, "_tdata_nz"}, int'(|m_tdata), 0);
        chk_int({tag, "_tlast"}, int'(m_tlast), 0);
        chk_int({tag, "_busy"}, int'(busy), 0);
        chk_int({tag, "_done"}, int'(frame_done), 0);
        chk_int({tag, "_err"}, int'(err_tlast), 0);
        chk_int({tag, "_count"}, int'(beat_count), 0);
        chk_int({tag, "_tready"}, treadys(), 0);
    endtask

    logic pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        int fd0;
        int c0;
        resetn    = 1'b0;
        enable    = 1'b0;
        frame_len = '0;
        clear_err = 1'b0;
        sd0 = '0; sd1 = '0; sd2 = '0; sd3 = '0;
        sv  = 4'h0;
        sl  = 4'h0;
        m_rdy = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_idle_zero("reset");
        resetn = 1'b1;
        @(posedge CLK);
        #1;

        // Basic 4-beat frame, enable dropped mid-frame
        frame_len = 16'd4;
        enable    = 1'b1;
        fd0       = fd_cnt;
        send(0, 4'h0, 1'b0);
        chk_int("latency_tvalid", int'(m_tvalid), 1);
        chk_int("beat_count_1", int'(beat_count), 1);
        enable = 1'b0;
        send(1, 4'h0, 1'b0);
        send(2, 4'h0, 1'b0);
        send(3, 4'hF, 1'b1);
        repeat (4) @(posedge CLK);
        #1;
        chk_int("f1_busy", int'(busy), 0);
        chk_int("f1_frame_done", fd_cnt - fd0, 1);
        chk_int("f1_err", int'(err_tlast), 0);
        chk_int("f1_sb_empty", sb.size(), 0);

        // Lane 2 late: no lane is consumed until all four are valid
        frame_len = 16'd2;
        enable    = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        enable = 1'b0;
        sd0 = lw(0, 0); sd1 = lw(1, 0); sd2 = lw(2, 0); sd3 = lw(3, 0);
        sv  = 4'b1011;
        repeat (3) begin
            @(negedge CLK);
            chk_int("lane2_wait_tready", treadys(), 0);
        end
        @(posedge CLK);
        #1;
        send(0, 4'h0, 1'b0);
        send(1, 4'hF, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        chk_int("lane2_busy", int'(busy), 0);

        // Output back-pressure 1,0,0,1 during a frame
        frame_len = 16'd4;
        enable    = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        enable = 1'b0;
        fork
            begin
                send(0, 4'h0, 1'b0);
                send(1, 4'h0, 1'b0);
                send(2, 4'h0, 1'b0);
                send(3, 4'hF, 1'b1);
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    @(posedge CLK);
                    #1;
                    m_rdy = pat[k];
                end
            end
        join
        m_rdy = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk_int("bp_sb_empty", sb.size(), 0);

        // 8-beat frame with enable dropped after beat 1, then frame_len=0
        frame_len = 16'd8;
        enable    = 1'b1;
        send(0, 4'h0, 1'b0);
        send(1, 4'h0, 1'b0);
        enable = 1'b0;
        for (int b = 2; b < 7; b++) send(b, 4'h0, 1'b0);
        send(7, 4'hF, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        chk_int("f8_busy", int'(busy), 0);
        chk_int("f8_count", int'(beat_count), 0);
        frame_len = 16'd0;
        enable    = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk_int("len0_busy", int'(busy), 0);
        enable = 1'b0;

        // frame_len=1: every beat is a last beat, frames back-to-back
        frame_len = 16'd1;
        enable    = 1'b1;
        send(0, 4'hF, 1'b1);
        c0 = cyc;
        send(1, 4'hF, 1'b1);
        enable = 1'b0;
        send(2, 4'hF, 1'b1);
        chk_int("len1_no_bubble", cyc - c0, 2);
        repeat (3) @(posedge CLK);
        #1;
        chk_int("len1_busy", int'(busy), 0);

        // tlast mismatch: lane 1 ends early on beat 1 of a 3-beat frame
        frame_len = 16'd3;
        enable    = 1'b1;
        send(0, 4'h0, 1'b0);
        enable = 1'b0;
        send(1, 4'b0010, 1'b1);
        repeat (2) @(posedge CLK);
        #1;
        sv = 4'hF;
        @(negedge CLK);
        chk_int("err_flag", int'(err_tlast), 1);
        chk_int("err_busy", int'(busy), 1);
        chk_int("err_tready", treadys(), 0);
        @(posedge CLK);
        #1;
        sv        = 4'h0;
        clear_err = 1'b1;
        @(posedge CLK);
        #1;
        clear_err = 1'b0;
        chk_int("clr_busy", int'(busy), 0);
        chk_int("clr_err", int'(err_tlast), 0);
        chk_int("clr_count", int'(beat_count), 0);
        chk_int("err_sb_empty", sb.size(), 0);

        // Reset while a stalled beat is pending at the output
        frame_len = 16'd4;
        enable    = 1'b1;
        m_rdy     = 1'b0;
        send(0, 4'h0, 1'b0);
        chk_int("pre_reset_tvalid", int'(m_tvalid), 1);
        sb.delete();
        resetn = 1'b0;
        enable = 1'b0;
        @(posedge CLK);
        #1;
        check_idle_zero("midreset");
        resetn = 1'b1;
        m_rdy  = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk_int("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
